// File: rtl/dma.sv
// Purpose : single-channel memory-to-memory word DMA engine for the ECO32 bus (responder + initiator).
// Latency : responder access 0 wait states; 2 cycles per word (RD, WR), 1 per word in fill mode.
// Backpres: initiator outputs are registered and held while m_wt=1; every wait cycle stalls the FSM one cycle.
//
// Ports:
//   clk, reset_n              system clock, async active-low reset
//   en, wr, addr, data_in     responder select/strobe/register select/write data
//   data_out, wt              responder read data (combinational register mux), wait (always 0)
//   irq                       registered DONE & IEN
//   m_en, m_wr, m_size,
//   m_addr, m_data_out        initiator request, direction, size (word), address, write data
//   m_data_in, m_wt           initiator read data, wait
//
// Optional feature: define DMA_FILL_EN to enable CTRL.FILL (pattern fill from SRC, no reads).
module dma #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             wr,
  input  logic [3:2]       addr,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  output logic             wt,
  output logic             irq,
  output logic             m_en,
  output logic             m_wr,
  output logic [1:0]       m_size,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_data_out,
  input  logic [31:0]      m_data_in,
  input  logic             m_wt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // SRC keeps all 32 bits so a fill pattern can use the low bits; they are
  // masked off on reads and on the bus address.
  logic [31:0]        r_src;
  logic [31:2]        r_dst;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_buf;
  logic               r_ien;
  logic               r_done;
  logic               r_irq;
  logic               r_m_en;
  logic               r_m_wr;
  logic [31:0]        r_m_addr;

  logic [31:0]        w_src_nxt;
  logic [31:2]        w_dst_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [31:0]        w_buf_nxt;
  logic [31:0]        w_src_rd;

  logic               w_busy;
  logic               w_wr_ctrl;
  logic               w_start;
  logic               w_go;
  logic               w_rd_done;
  logic               w_wr_done;
  logic               w_set_done;
  logic               w_fill_req;   // FILL bit of the CTRL write carrying START
  logic               w_fill_on;    // fill mode of the running transfer
  logic               w_fill_bit;   // CTRL bit3 read value

`ifdef DMA_FILL_EN
  logic               r_fill;

  assign w_fill_req = data_in[3];
  assign w_fill_on  = r_fill;
  assign w_fill_bit = r_fill;
  assign w_src_rd   = {r_src[31:2], 2'b00};

  // FILL is frozen while a transfer runs so the FSM loop cannot change mid-flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill <= 1'b0;
    end else if (w_wr_ctrl && !w_busy) begin
      r_fill <= data_in[3];
    end
  end
`else
  assign w_fill_req = 1'b0;
  assign w_fill_on  = 1'b0;
  assign w_fill_bit = 1'b0;
  // Low bits are never written in this build, so the register reads directly.
  assign w_src_rd   = r_src;
`endif

  assign w_busy    = (r_state != S_IDLE);
  assign w_wr_ctrl = en && wr && (addr == 2'd3);
  assign w_start   = w_wr_ctrl && data_in[0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_rd_done   = 1'b0;
    w_wr_done   = 1'b0;
    w_set_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // START is only decoded here, which is what makes it ignored while BUSY.
        if (w_start) begin
          if (r_cnt == '0) begin
            w_set_done = 1'b1;
          end else begin
            w_go        = 1'b1;
            w_state_nxt = w_fill_req ? S_WR : S_RD;
          end
        end
      end
      S_RD: begin
        if (!m_wt) begin
          w_rd_done   = 1'b1;
          w_state_nxt = S_WR;
        end
      end
      S_WR: begin
        if (!m_wt) begin
          w_wr_done = 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_IDLE;
            w_set_done  = 1'b1;
          end else begin
            w_state_nxt = w_fill_on ? S_WR : S_RD;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    w_src_nxt = r_src;
    w_dst_nxt = r_dst;
    w_cnt_nxt = r_cnt;
    w_buf_nxt = r_buf;

    if (en && wr && !w_busy) begin
      case (addr)
`ifdef DMA_FILL_EN
        2'd0:    w_src_nxt = data_in;
`else
        2'd0:    w_src_nxt = {data_in[31:2], 2'b00};
`endif
        2'd1:    w_dst_nxt = data_in[31:2];
        2'd2:    w_cnt_nxt = data_in[CNT_W-1:0];
        default: ;
      endcase
    end

    if (w_rd_done) begin
      w_buf_nxt = m_data_in;
    end

    // Fill transfers never read: the pattern is loaded once at START.
    if (w_go && w_fill_req) begin
      w_buf_nxt = r_src;
    end

    if (w_wr_done) begin
      if (!w_fill_on) begin
        w_src_nxt = r_src + 32'd4;
      end
      w_dst_nxt = r_dst + 30'd1;
      if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_cnt    <= '0;
      r_buf    <= '0;
      r_ien    <= 1'b0;
      r_done   <= 1'b0;
      r_irq    <= 1'b0;
      r_m_en   <= 1'b0;
      r_m_wr   <= 1'b0;
      r_m_addr <= '0;
    end else begin
      r_src <= w_src_nxt;
      r_dst <= w_dst_nxt;
      r_cnt <= w_cnt_nxt;
      r_buf <= w_buf_nxt;

      if (w_wr_ctrl) begin
        r_ien <= data_in[1];
      end

      // Completion beats a simultaneous DONE-clear.
      if (w_set_done) begin
        r_done <= 1'b1;
      end else if (w_wr_ctrl && data_in[2]) begin
        r_done <= 1'b0;
      end

      r_irq <= r_done && r_ien;

      // Bus outputs are computed from the next state/addresses so they are
      // plain flops: stable during waits, and m_en stays high between words.
      r_m_en   <= (w_state_nxt != S_IDLE);
      r_m_wr   <= (w_state_nxt == S_WR);
      r_m_addr <= (w_state_nxt == S_WR) ? {w_dst_nxt, 2'b00}
                                        : {w_src_nxt[31:2], 2'b00};
    end
  end

  // ---------------------------------------------------------- responder
  always_comb begin
    data_out = '0;
    case (addr)
      2'd0:    data_out = w_src_rd;
      2'd1:    data_out = {r_dst, 2'b00};
      2'd2:    data_out = 32'(r_cnt);
      default: data_out = {28'd0, w_fill_bit, r_done, r_ien, w_busy};
    endcase
  end

  assign wt         = 1'b0;
  assign irq        = r_irq;
  assign m_en       = r_m_en;
  assign m_wr       = r_m_wr;
  assign m_size     = 2'b10;
  assign m_addr     = r_m_addr;
  assign m_data_out = r_buf;

endmodule

// File: tb/tb_dma.sv
// Purpose : directed self-checking bench for dma (bus memory model returns 0xA0+addr).
// Latency : checks cycle counts from START to DONE and irq one edge later.
// Backpres: m_wt generator can insert 2 wait cycles per access or hold wait forever.
module tb_dma;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        wr;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        wt;
  logic        irq;
  logic        m_en;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_data_out;
  logic [31:0] m_data_in;
  logic        m_wt;

  int checks = 0;
  int errors = 0;

  // wait generator
  logic wmode  = 1'b0;
  logic wforce = 1'b0;
  int   wcnt   = 0;

  // bus monitor
  logic [64:0] txlog [0:63];
  int          ntx      = 0;
  int          unstable = 0;
  logic        p_wait   = 1'b0;
  logic        p_en, p_wr;
  logic [31:0] p_addr, p_dat;

  dma #(.CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .wt         (wt),
    .irq        (irq),
    .m_en       (m_en),
    .m_wr       (m_wr),
    .m_size     (m_size),
    .m_addr     (m_addr),
    .m_data_out (m_data_out),
    .m_data_in  (m_data_in),
    .m_wt       (m_wt)
  );

  always #5 clk = ~clk;

  assign m_data_in = 32'hA0 + m_addr;
  assign m_wt      = wforce || (wmode && (wcnt < 2));

  always @(posedge clk) begin
    if (m_en && m_wt) wcnt <= wcnt + 1;
    else if (m_en)    wcnt <= 0;
  end

  always @(posedge clk) begin
    if (m_en && !m_wt && ntx < 64) begin
      txlog[ntx] <= {m_wr, m_addr, (m_wr ? m_data_out : m_data_in)};
      ntx        <= ntx + 1;
    end
    if (p_wait && (m_en !== p_en || m_wr !== p_wr || m_addr !== p_addr || m_data_out !== p_dat))
      unstable <= unstable + 1;
    p_wait <= m_en && m_wt;
    p_en   <= m_en;
    p_wr   <= m_wr;
    p_addr <= m_addr;
    p_dat  <= m_data_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_tx(input string tag, input int idx, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    logic [64:0] exp;
    logic [64:0] obs;
    exp = {w, a, d};
    obs = (idx < 64) ? txlog[idx] : 65'd0;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed wr=%0b addr=%08h data=%08h expected wr=%0b addr=%08h data=%08h",
             tag, obs[64], obs[63:32], obs[31:0], w, a, d);
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    #1;
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = a;
    #1;
    d  = data_out;
    en = 1'b0;
  endtask

  // Counts edges until CTRL.DONE reads 1; returns at #1 after that edge.
  task automatic wait_done(output int cyc);
    cyc  = 0;
    addr = 2'd3;
    #0;
    while (data_out[2] !== 1'b1 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          cyc;
    int          base;

    reset_n = 1'b0; en = 1'b0; wr = 1'b0; addr = 2'd0; data_in = 32'd0;

    // ---------------- reset state
    #2;
    chk("rst_m_en",  32'(m_en), 32'd0);
    chk("rst_m_wr",  32'(m_wr), 32'd0);
    chk("rst_irq",   32'(irq),  32'd0);
    chk("rst_wt",    32'(wt),   32'd0);
    chk("rst_msize", 32'(m_size), 32'd2);
    for (int i = 0; i < 4; i++) begin
      addr = 2'(i);
      #1;
      chk("rst_reg", data_out, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // ---------------- 3-word transfer, no waits
    wr_reg(2'd0, 32'h100);
    wr_reg(2'd1, 32'h200);
    wr_reg(2'd2, 32'd3);
    base = ntx;
    wr_reg(2'd3, 32'h3);
    chk("start_m_en", 32'(m_en), 32'd1);
    wait_done(cyc);
    chk("main_cycles", cyc, 32'd6);
    chk("main_irq_at_done", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("main_irq_next", 32'(irq), 32'd1);
    chk("main_m_en_idle", 32'(m_en), 32'd0);
    chk("main_ntx", ntx - base, 32'd6);
    chk_tx("main_tx0", base + 0, 1'b0, 32'h100, 32'h1A0);
    chk_tx("main_tx1", base + 1, 1'b1, 32'h200, 32'h1A0);
    chk_tx("main_tx2", base + 2, 1'b0, 32'h104, 32'h1A4);
    chk_tx("main_tx3", base + 3, 1'b1, 32'h204, 32'h1A4);
    chk_tx("main_tx4", base + 4, 1'b0, 32'h108, 32'h1A8);
    chk_tx("main_tx5", base + 5, 1'b1, 32'h208, 32'h1A8);
    rd_reg(2'd0, rd); chk("main_src",   rd, 32'h10C);
    rd_reg(2'd1, rd); chk("main_dst",   rd, 32'h20C);
    rd_reg(2'd2, rd); chk("main_count", rd, 32'd0);
    rd_reg(2'd3, rd); chk("main_ctrl",  rd, 32'h6);

    // ---------------- same transfer, 2 wait cycles per access
    wr_reg(2'd3, 32'h6);
    wr_reg(2'd0, 32'h100);
    wr_reg(2'd1, 32'h200);
    wr_reg(2'd2, 32'd3);
    wmode = 1'b1;
    base  = ntx;
    wr_reg(2'd3, 32'h3);
    wait_done(cyc);
    wmode = 1'b0;
    chk("wait_cycles", cyc, 32'd18);
    chk("wait_stable", unstable, 32'd0);
    chk("wait_ntx", ntx - base, 32'd6);
    chk_tx("wait_tx2", base + 2, 1'b0, 32'h104, 32'h1A4);
    chk_tx("wait_tx5", base + 5, 1'b1, 32'h208, 32'h1A8);

    // ---------------- START with COUNT=0
    wr_reg(2'd3, 32'h6);
    base = ntx;
    wr_reg(2'd3, 32'h3);
    rd_reg(2'd3, rd); chk("cnt0_ctrl_done", rd, 32'h6);
    chk("cnt0_no_m_en", 32'(m_en), 32'd0);
    @(posedge clk); #1;
    chk("cnt0_irq", 32'(irq), 32'd1);
    wr_reg(2'd3, 32'h4);
    rd_reg(2'd3, rd); chk("cnt0_ctrl_clr", rd, 32'h0);
    @(posedge clk); #1;
    chk("cnt0_irq_clr", 32'(irq), 32'd0);
    chk("cnt0_ntx", ntx - base, 32'd0);

    // ---------------- writes and START while BUSY
    wr_reg(2'd0, 32'h300);
    wr_reg(2'd1, 32'h400);
    wr_reg(2'd2, 32'd2);
    base = ntx;
    wr_reg(2'd3, 32'h1);
    wr_reg(2'd2, 32'd9);
    wr_reg(2'd3, 32'h3);
    rd_reg(2'd3, rd); chk("busy_ctrl_ien", rd, 32'h3);
    rd_reg(2'd2, rd); chk("busy_count_live", rd, 32'd1);
    wait_done(cyc);
    chk("busy_done", 32'(data_out[2]), 32'd1);
    chk("busy_ntx", ntx - base, 32'd4);
    rd_reg(2'd0, rd); chk("busy_src",   rd, 32'h308);
    rd_reg(2'd1, rd); chk("busy_dst",   rd, 32'h408);
    rd_reg(2'd2, rd); chk("busy_count", rd, 32'd0);
    @(posedge clk); #1;
    chk("busy_irq", 32'(irq), 32'd1);

    // ---------------- SRC wrap
    wr_reg(2'd3, 32'h4);
    wr_reg(2'd0, 32'hFFFF_FFFC);
    wr_reg(2'd1, 32'h500);
    wr_reg(2'd2, 32'd2);
    base = ntx;
    wr_reg(2'd3, 32'h1);
    wait_done(cyc);
    chk("wrap_cycles", cyc, 32'd4);
    chk_tx("wrap_tx0", base + 0, 1'b0, 32'hFFFF_FFFC, 32'h0000_009C);
    chk_tx("wrap_tx1", base + 1, 1'b1, 32'h500,       32'h0000_009C);
    chk_tx("wrap_tx2", base + 2, 1'b0, 32'h0000_0000, 32'h0000_00A0);
    chk_tx("wrap_tx3", base + 3, 1'b1, 32'h504,       32'h0000_00A0);
    rd_reg(2'd0, rd); chk("wrap_src", rd, 32'h4);

`ifdef DMA_FILL_EN
    // ---------------- fill
    wr_reg(2'd3, 32'h4);
    wr_reg(2'd0, 32'hDEAD_BEEF);
    wr_reg(2'd1, 32'h600);
    wr_reg(2'd2, 32'd4);
    base = ntx;
    wr_reg(2'd3, 32'h9);
    wait_done(cyc);
    chk("fill_cycles", cyc, 32'd4);
    chk("fill_ntx", ntx - base, 32'd4);
    for (int i = 0; i < 4; i++)
      chk_tx("fill_tx", base + i, 1'b1, 32'h600 + 32'(4 * i), 32'hDEAD_BEEF);
    rd_reg(2'd0, rd); chk("fill_src", rd, 32'hDEAD_BEEC);
    rd_reg(2'd1, rd); chk("fill_dst", rd, 32'h610);
    rd_reg(2'd3, rd); chk("fill_ctrl", rd, 32'hC);
`else
    // ---------------- FILL bit absent
    wr_reg(2'd3, 32'h8);
    rd_reg(2'd3, rd); chk("nofill_ctrl", rd, 32'h4);
`endif

    // ---------------- reset mid-RD while waiting
    wr_reg(2'd0, 32'h700);
    wr_reg(2'd2, 32'd1);
    wforce = 1'b1;
    wr_reg(2'd3, 32'h3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_m_en_before", 32'(m_en), 32'd1);
    chk("mid_m_wr_before", 32'(m_wr), 32'd0);
    chk("mid_irq_before",  32'(irq),  32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_m_en_reset", 32'(m_en), 32'd0);
    chk("mid_irq_reset",  32'(irq),  32'd0);
    for (int i = 0; i < 4; i++) begin
      addr = 2'(i);
      #1;
      chk("mid_reg_reset", data_out, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wforce  = 1'b0;
    @(posedge clk); #1;
    chk("mid_m_en_after", 32'(m_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
